// File: rtl/spi_wrapper_if.sv
// Purpose: SPI pin bundle between an external master and the spi_wrapper peripheral.
// Latency: none; this is wiring only.
// Backpressure: none; the master paces every bit and SS_n frames each transfer.
// Signals: SS_n  - slave select, active low (master -> slave)
//          MOSI  - serial data into the peripheral (master -> slave)
//          MISO  - serial read data out of the peripheral, MSB first (slave -> master)
interface spi_wrapper_if;
    logic SS_n;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/spi_wrapper.sv
// Purpose: memory-mapped SPI peripheral; an SPI slave front end driving a 256 x 8 RAM.
// Latency: command acts 1 cycle after the last payload bit; first MISO bit 4 cycles after it.
// Backpressure: none; SS_n high aborts any frame or read-out and returns the slave to IDLE.
// Ports: clk   - system clock, everything on the rising edge
//        rst_n - synchronous reset, active HIGH despite the name
//        spi   - slave modport carrying SS_n, MOSI and MISO

// ---------------------------------------------------------------------------
// Purpose: serial-to-parallel SPI slave; emits 10-bit command words, serialises read bytes.
// Latency: rx_valid 1 cycle after the 10th payload bit; MISO bit 7 lands 3 cycles after tx_valid.
// Backpressure: none; SS_n high clears the frame, a partial frame never raises rx_valid.
// ---------------------------------------------------------------------------
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,      // active high
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);
    typedef enum logic [3:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_LOAD,
        TX_SHIFT,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [8:0] rx_shift;
    logic [7:0] tx_shift;
    logic       rd_addr_flag;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            rx_shift     <= 9'd0;
            rx_data      <= 10'd0;
            rx_valid     <= 1'b0;
            tx_shift     <= 8'd0;
            rd_addr_flag <= 1'b0;
            miso         <= 1'b0;
        end else begin
            // Single-cycle pulse and idle-low MISO unless a state below says otherwise.
            rx_valid <= 1'b0;
            miso     <= 1'b0;

            if (ss_n) begin
                // Deselect wins over everything: drop the frame or read-out in progress.
                state   <= IDLE;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CHK_CMD;
                        bit_cnt <= 4'd0;
                    end

                    CHK_CMD: begin
                        if (!mosi) begin
                            state <= WRITE;
                        end else if (rd_addr_flag) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end

                    WRITE, READ_ADD, READ_DATA: begin
                        rx_shift <= {rx_shift[7:0], mosi};
                        if (bit_cnt == 4'd9) begin
                            rx_data  <= {rx_shift, mosi};
                            rx_valid <= 1'b1;
                            bit_cnt  <= 4'd0;
                            if (state == READ_ADD) begin
                                rd_addr_flag <= 1'b1;
                                state        <= DONE;
                            end else if (state == READ_DATA) begin
                                rd_addr_flag <= 1'b0;
                                state        <= TX_WAIT;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end

                    TX_WAIT: begin
                        if (tx_valid) begin
                            tx_shift <= tx_data;
                            state    <= TX_LOAD;
                        end
                    end

                    // Alignment slot: keeps the first MISO bit a fixed 4 cycles
                    // after the last payload bit regardless of RAM read timing.
                    TX_LOAD: begin
                        state <= TX_SHIFT;
                    end

                    TX_SHIFT: begin
                        miso     <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end

                    // Frame finished; hold MISO low and ignore MOSI until SS_n rises,
                    // so a master that keeps SS_n low cannot start a phantom frame.
                    DONE: begin
                        state <= DONE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Purpose: 256 x 8 single-port RAM decoding 2-bit commands from the SPI slave.
// Latency: every command takes effect on the edge that samples rx_valid; tx_valid 1 cycle later.
// Backpressure: none; each rx_valid pulse is executed unconditionally.
// ---------------------------------------------------------------------------
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,      // active high
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid
);
    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [1:0]           cmd;
    logic [7:0]           data;

    assign cmd  = rx_data[9:8];
    assign data = rx_data[7:0];

    // Storage has no reset; writes are simply blocked while reset is held.
    always_ff @(posedge clk) begin
        if (!rst_n && rx_valid && (cmd == 2'b01)) begin
            mem[wr_addr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    2'b00: wr_addr <= data[ADDR_SIZE-1:0];
                    2'b10: rd_addr <= data[ADDR_SIZE-1:0];
                    2'b11: begin
                        tx_data  <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: begin
                        // 2'b01 is the storage write handled above.
                    end
                endcase
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Purpose: top level tying the SPI slave to the RAM and to the SPI pin interface.
// Latency: write/address commands effective 1 cycle after the last payload bit.
// Backpressure: none; the external master owns all pacing via SS_n.
// ---------------------------------------------------------------------------
module spi_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst_n,   // active high
    spi_wrapper_if.slave  spi
);
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       miso;

    spi_slave u_slave (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (spi.SS_n),
        .mosi     (spi.MOSI),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    spi_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    assign spi.MISO = miso;
endmodule

// File: tb/tb_spi_wrapper.sv
// Purpose: directed self-checking bench for spi_wrapper driving SPI frames as the master.
// Latency: MISO sampled on falling edges; read bits expected after edges E+4..E+11.
// Backpressure: none; the bench paces every bit and frames transfers with SS_n.
module tb_spi_wrapper;
    logic clk;
    logic rst_n;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;

    spi_wrapper_if spi ();

    spi_wrapper #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (spi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drives SS_n low, the select bit, then the 10 payload bits MSB first.
    // Returns just after the falling edge that presents payload bit 0 (edge E follows).
    task automatic send_frame(input logic sel, input logic [9:0] payload);
        @(negedge clk);
        spi.SS_n = 1'b0;
        spi.MOSI = 1'b0;
        @(negedge clk);
        spi.MOSI = sel;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            spi.MOSI = payload[i];
        end
    endtask

    task automatic end_frame(input string tag);
        @(negedge clk);
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        @(negedge clk);
        check(tag, spi.MISO, 1'b0);
    endtask

    task automatic write_cmd(input logic [1:0] cmd, input logic [7:0] data, input string tag);
        send_frame(1'b0, {cmd, data});
        end_frame(tag);
    endtask

    // Address frame then data frame; checks MISO across E+1..E+12.
    task automatic read_byte(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        send_frame(1'b1, {2'b10, addr});
        end_frame({tag, "_addr_idle"});
        send_frame(1'b1, {2'b11, 8'h00});
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            spi.MOSI = k[0];   // toggling MOSI must not disturb the read-out
            if (k >= 5 && k <= 12) begin
                check($sformatf("%s_bit%0d", tag, 12 - k), spi.MISO, exp[12 - k]);
            end else begin
                check($sformatf("%s_quiet%0d", tag, k), spi.MISO, 1'b0);
            end
        end
        end_frame({tag, "_end"});
    endtask

    initial begin
        logic [9:0] part;

        // Reset with unknown pins.
        rst_n    = 1'b1;
        spi.SS_n = 1'bx;
        spi.MOSI = 1'bx;
        repeat (3) begin
            @(negedge clk);
            check("reset_miso", spi.MISO, 1'b0);
        end
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        rst_n    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_miso", spi.MISO, 1'b0);
        end

        // wr_addr <= FF, mem[FF] <= FC, then read back through READ_ADD/READ_DATA.
        write_cmd(2'b00, 8'hFF, "wr_addr_ff");
        write_cmd(2'b01, 8'hFC, "wr_data_fc");
        read_byte(8'hFF, 8'hFC, "rd_ff");

        // Further addresses and patterns, checking no aliasing onto FF.
        write_cmd(2'b00, 8'h00, "wr_addr_00");
        write_cmd(2'b01, 8'hA5, "wr_data_a5");
        write_cmd(2'b00, 8'h80, "wr_addr_80");
        write_cmd(2'b01, 8'h00, "wr_data_00");
        read_byte(8'h00, 8'hA5, "rd_00");
        read_byte(8'h80, 8'h00, "rd_80_zero");
        read_byte(8'hFF, 8'hFC, "rd_ff_again");
        write_cmd(2'b01, 8'hFF, "wr_data_ff");
        read_byte(8'h80, 8'hFF, "rd_80_ff");

        // Abort a mem write after 5 payload bits; mem[00] must keep A5.
        write_cmd(2'b00, 8'h00, "wr_addr_00b");
        part = {2'b01, 8'h3C};
        @(negedge clk);
        spi.SS_n = 1'b0;
        spi.MOSI = 1'b0;
        @(negedge clk);
        spi.MOSI = 1'b0;
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk);
            spi.MOSI = part[i];
        end
        end_frame("abort_idle");
        read_byte(8'h00, 8'hA5, "rd_after_abort");
        write_cmd(2'b01, 8'h3C, "wr_data_3c");
        read_byte(8'h00, 8'h3C, "rd_00_3c");

        // Reset in the middle of a READ_DATA shift of mem[80] = FF.
        send_frame(1'b1, {2'b10, 8'h80});
        end_frame("rst_seq_addr_idle");
        send_frame(1'b1, {2'b11, 8'h00});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k >= 5) begin
                check($sformatf("pre_rst_bit%0d", 12 - k), spi.MISO, 1'b1);
            end
        end
        rst_n    = 1'b1;
        spi.SS_n = 1'b1;
        @(negedge clk);
        check("mid_rst_miso", spi.MISO, 1'b0);
        @(negedge clk);
        check("mid_rst_miso_hold", spi.MISO, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("post_rst_idle", spi.MISO, 1'b0);

        // Flag was cleared by reset: a select-1 frame must be an address frame first.
        read_byte(8'h00, 8'h3C, "rd_after_rst");
        read_byte(8'hFF, 8'hFC, "rd_ff_final");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
